// File: rtl/block_assembler_if.sv
// Word-stream input and block-stream output of the block assembler, both valid/ready.
// The slave modport is the assembler side and the master modport is the producer/consumer side.
interface block_assembler_if #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 44,
    parameter int COUNT_W   = $clog2(NUM_WORDS + 1)
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WORD_W-1:0]             in_data;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [WORD_W*NUM_WORDS-1:0]   out_data;
    logic [COUNT_W-1:0]            out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/block_assembler.sv
// Double-buffered word-to-block packer. A block appears one cycle after its last word; a full output stalls
// the fill side for a single block only (in_ready drops while that block waits, then returns the cycle after it moves).
module block_assembler #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 44,
    parameter int COUNT_W   = $clog2(NUM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    block_assembler_if.slave  bus
);
    typedef enum logic {
        FILLING = 1'b0,
        PENDING = 1'b1
    } state_t;

    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] blk_t;

    localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(NUM_WORDS - 1);

    state_t             state_q, state_d;
    blk_t               fill_q, fill_d, fill_wr;
    blk_t               out_data_q, out_data_d;
    logic [COUNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [COUNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready;
    logic               accept;
    logic               complete;
    logic               slot_free;

    assign in_ready      = (state_q == FILLING);
    assign accept        = bus.in_valid & in_ready;
    assign complete      = accept & ((fill_cnt_q == LAST_CNT) | bus.in_last);
    assign slot_free     = ~out_valid_q | bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    // Word k lands in array element NUM_WORDS-1-k so the first word sits at the MSBs.
    always_comb begin
        fill_wr = fill_q;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (fill_cnt_q == COUNT_W'(i)) begin
                fill_wr[NUM_WORDS-1-i] = bus.in_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        fill_cnt_d  = fill_cnt_q;
        pend_cnt_d  = pend_cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILLING: begin
                if (accept) begin
                    if (complete && slot_free) begin
                        out_data_d  = fill_wr;
                        out_count_d = fill_cnt_q + COUNT_W'(1);
                        out_valid_d = 1'b1;
                        fill_d      = '0;
                        fill_cnt_d  = '0;
                    end else if (complete) begin
                        // Block is finished but the output is still occupied; park it here.
                        fill_d      = fill_wr;
                        pend_cnt_d  = fill_cnt_q + COUNT_W'(1);
                        state_d     = PENDING;
                    end else begin
                        fill_d      = fill_wr;
                        fill_cnt_d  = fill_cnt_q + COUNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (slot_free) begin
                    out_data_d  = fill_q;
                    out_count_d = pend_cnt_q;
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                    fill_cnt_d  = '0;
                    state_d     = FILLING;
                end
            end
            default: state_d = FILLING;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILLING;
            fill_q      <= '0;
            fill_cnt_q  <= '0;
            pend_cnt_q  <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            fill_cnt_q  <= fill_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_block_assembler.sv
// Bench for block_assembler: directed cases on the 8x44 build, random traffic on a 32x4 build,
// with a scoreboard per build fed from accepted words and drained on output handshakes.
module tb_block_assembler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    block_assembler_if #(.WORD_W(8),  .NUM_WORDS(44)) m_if ();
    block_assembler_if #(.WORD_W(32), .NUM_WORDS(4))  s_if ();

    block_assembler #(.WORD_W(8), .NUM_WORDS(44)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    block_assembler #(.WORD_W(32), .NUM_WORDS(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard for the 8x44 build ----------------
    logic [351:0] m_exp_q[$];
    logic [5:0]   m_cnt_q[$];
    logic [351:0] m_buf  = '0;
    int           m_n    = 0;
    logic         m_stall = 1'b0;
    logic [351:0] m_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_exp_q.delete();
            m_cnt_q.delete();
            m_buf   = '0;
            m_n     = 0;
            m_stall = 1'b0;
        end else begin
            if (m_stall) begin
                chk("m_hold_vld", 352'(m_if.out_valid), 352'(1));
                chk("m_hold_dat", m_if.out_data, m_prev);
            end
            m_stall = m_if.out_valid && !m_if.out_ready;
            m_prev  = m_if.out_data;
            if (m_if.out_valid && m_if.out_ready) begin
                chk("m_fire_expected", 352'(m_exp_q.size() > 0), 352'(1));
                if (m_exp_q.size() > 0) begin
                    chk("m_blk_dat", m_if.out_data, m_exp_q.pop_front());
                    chk("m_blk_cnt", 352'(m_if.out_count), 352'(m_cnt_q.pop_front()));
                end
            end
            if (m_if.in_valid && m_if.in_ready) begin
                m_buf[(44-m_n)*8-1 -: 8] = m_if.in_data;
                m_n++;
                if (m_n == 44 || m_if.in_last) begin
                    m_exp_q.push_back(m_buf);
                    m_cnt_q.push_back(6'(m_n));
                    m_buf = '0;
                    m_n   = 0;
                end
            end
        end
    end

    // ---------------- scoreboard for the 32x4 build ----------------
    logic [127:0] s_exp_q[$];
    logic [2:0]   s_cnt_q[$];
    logic [127:0] s_buf    = '0;
    int           s_n      = 0;
    int           s_pushed = 0;
    int           s_popped = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_exp_q.delete();
            s_cnt_q.delete();
            s_buf = '0;
            s_n   = 0;
        end else begin
            if (s_if.out_valid && s_if.out_ready) begin
                chk("s_fire_expected", 352'(s_exp_q.size() > 0), 352'(1));
                if (s_exp_q.size() > 0) begin
                    chk("s_blk_dat", 352'(s_if.out_data), 352'(s_exp_q.pop_front()));
                    chk("s_blk_cnt", 352'(s_if.out_count), 352'(s_cnt_q.pop_front()));
                    s_popped++;
                end
            end
            if (s_if.in_valid && s_if.in_ready) begin
                s_buf[(4-s_n)*32-1 -: 32] = s_if.in_data;
                s_n++;
                if (s_n == 4 || s_if.in_last) begin
                    s_exp_q.push_back(s_buf);
                    s_cnt_q.push_back(3'(s_n));
                    s_buf = '0;
                    s_n   = 0;
                    s_pushed++;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic m_send(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.in_data  = d;
        m_if.in_last  = l;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = m_if.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("m_accept_timeout", 352'(ok), 352'(1));
    endtask

    task automatic m_idle();
        m_if.in_valid = 1'b0;
        m_if.in_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [351:0] e1, e2, e3;

    initial begin
        for (int k = 0; k < 44; k++) begin
            e1[(44-k)*8-1 -: 8] = 8'(8'h40 + k);
            e2[(44-k)*8-1 -: 8] = 8'(8'h40 + 44 + k);
            e3[(44-k)*8-1 -: 8] = 8'(8'h10 + k);
        end

        m_if.in_valid  = 1'b1;
        m_if.in_data   = 8'hFF;
        m_if.in_last   = 1'b0;
        m_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b0;
        s_if.in_data   = '0;
        s_if.in_last   = 1'b0;
        s_if.out_ready = 1'b0;

        // Reset held across two edges with in_valid high, released between edges.
        #17;
        rst_n = 1'b1;
        #1;
        chk("t1_in_ready",  352'(m_if.in_ready),  352'(1));
        chk("t1_out_valid", 352'(m_if.out_valid), 352'(0));
        chk("t1_out_data",  m_if.out_data,        352'(0));
        chk("t1_out_count", 352'(m_if.out_count), 352'(0));
        m_idle();
        tick(1);

        // Full block with a free output.
        m_if.out_ready = 1'b1;
        for (int i = 1; i <= 44; i++) begin
            if (i == 44) chk("t2_not_early", 352'(m_if.out_valid), 352'(0));
            m_send(8'(i), 1'b0);
        end
        m_idle();
        chk("t2_latency",  352'(m_if.out_valid),       352'(1));
        chk("t2_msb_word", 352'(m_if.out_data[351:344]), 352'(8'h01));
        chk("t2_lsb_word", 352'(m_if.out_data[7:0]),     352'(8'h2C));
        chk("t2_count",    352'(m_if.out_count),         352'(44));
        tick(1);
        chk("t2_drained",  352'(m_if.out_valid),       352'(0));

        // Short blocks closed by in_last.
        m_send(8'hA0, 1'b0);
        m_send(8'hA1, 1'b0);
        m_send(8'hA2, 1'b1);
        m_idle();
        chk("t3_head",  352'(m_if.out_data[351:328]), 352'(24'hA0A1A2));
        chk("t3_rest",  352'(m_if.out_data[327:0]),   352'(0));
        chk("t3_count", 352'(m_if.out_count),         352'(3));
        tick(1);
        m_send(8'h55, 1'b1);
        m_idle();
        chk("t3_next_msb",  352'(m_if.out_data[351:344]), 352'(8'h55));
        chk("t3_next_rest", 352'(m_if.out_data[343:0]),   352'(0));
        chk("t3_next_cnt",  352'(m_if.out_count),         352'(1));
        tick(1);

        // Backpressure: second block parks behind the first.
        m_if.out_ready = 1'b0;
        for (int i = 0; i < 88; i++) begin
            m_send(8'(8'h40 + i), 1'b0);
            if (i == 43) begin
                chk("t4_blk1_vld", 352'(m_if.out_valid), 352'(1));
                chk("t4_blk1_dat", m_if.out_data, e1);
            end
        end
        m_idle();
        chk("t4_inrdy_drop", 352'(m_if.in_ready), 352'(0));
        chk("t4_blk1_hold",  m_if.out_data,       e1);
        tick(2);
        chk("t4_inrdy_low",  352'(m_if.in_ready), 352'(0));
        m_if.out_ready = 1'b1;
        tick(1);
        m_if.out_ready = 1'b0;
        chk("t4_still_vld", 352'(m_if.out_valid), 352'(1));
        chk("t4_blk2_dat",  m_if.out_data,        e2);
        chk("t4_blk2_cnt",  352'(m_if.out_count), 352'(44));
        tick(1);
        chk("t4_inrdy_back", 352'(m_if.in_ready), 352'(1));
        m_if.out_ready = 1'b1;
        tick(1);
        chk("t4_empty", 352'(m_if.out_valid), 352'(0));

        // Asynchronous reset mid-fill with a block still held on the output.
        m_if.out_ready = 1'b0;
        m_send(8'hC3, 1'b1);
        m_idle();
        for (int i = 0; i < 20; i++) m_send(8'(8'hE0 + i), 1'b0);
        m_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_vld_clr", 352'(m_if.out_valid), 352'(0));
        chk("t5_dat_clr", m_if.out_data,        352'(0));
        chk("t5_cnt_clr", 352'(m_if.out_count), 352'(0));
        chk("t5_inrdy",   352'(m_if.in_ready),  352'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        for (int k = 0; k < 44; k++) m_send(8'(8'h10 + k), 1'b0);
        m_idle();
        chk("t5_clean_dat", m_if.out_data,        e3);
        chk("t5_clean_cnt", 352'(m_if.out_count), 352'(44));
        tick(2);
        chk("t5_sb_empty", 352'(m_exp_q.size()), 352'(0));

        // Random traffic on the 32x4 build.
        for (int cyc = 0; cyc < 40000 && s_pushed < 1000; cyc++) begin
            s_if.in_valid  = ($urandom_range(3) != 0);
            s_if.in_data   = $urandom;
            s_if.in_last   = ($urandom_range(5) == 0);
            s_if.out_ready = ($urandom_range(2) != 0);
            tick(1);
        end
        s_if.in_valid  = 1'b0;
        s_if.in_last   = 1'b0;
        s_if.out_ready = 1'b1;
        tick(4);
        chk("t6_pushed",   352'(s_pushed),        352'(1000));
        chk("t6_popped",   352'(s_popped),        352'(s_pushed));
        chk("t6_sb_empty", 352'(s_exp_q.size()),  352'(0));
        chk("t6_idle",     352'(s_if.out_valid),  352'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
